serv_bus_arbiter: RTL
=====================

# serv_bus_arbiter

Two-master to one-slave bus arbiter that lets the SERV core's instruction bus and data bus share a single Wishbone-style memory/peripheral port. It sits between `serv_top`'s ibus/dbus ports and the system interconnect in the synth wrapper, sequences one transaction at a time, and holds the grant until the slave acknowledges. An optional watchdog terminates transactions the slave never acknowledges.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles a granted transaction may wait for `i_wb_ack`. Used only with `SERV_BUS_TIMEOUT_EN`. Legal range is 1..65535.
- `ERR_RDATA`, default 32'hDEAD_BEEF: read data returned on a timed-out transaction.
- `clk` in, 1: single clock. All logic is rising-edge.
- `i_rst` in, 1: asynchronous, active-high reset.
- `i_ibus_adr` in, 32: instruction fetch address.
- `i_ibus_cyc` in, 1: instruction request.
- `o_ibus_rdt` out, 32: fetch data.
- `o_ibus_ack` out, 1: fetch acknowledge.
- `i_dbus_adr` in, 32: data address.
- `i_dbus_dat` in, 32: write data.
- `i_dbus_sel` in, 4: byte enables.
- `i_dbus_we` in, 1: write strobe.
- `i_dbus_cyc` in, 1: data request.
- `o_dbus_rdt` out, 32: load data.
- `o_dbus_ack` out, 1: data acknowledge.
- `o_wb_adr` out, 32; `o_wb_dat` out, 32; `o_wb_sel` out, 4; `o_wb_we` out, 1; `o_wb_cyc` out, 1: shared slave port.
- `i_wb_rdt` in, 32; `i_wb_ack` in, 1: slave response.
- `o_timeout` out, 1: one-cycle pulse when the watchdog fires.

## Operation
- The FSM has three states: IDLE, GNT_I and GNT_D. Reset state is IDLE.
- **From IDLE:**
  - Only `i_dbus_cyc` high → GNT_D.
  - Only `i_ibus_cyc` high → GNT_I.
  - Both high → the master not served last wins (round-robin). A `last` flag records this; its reset value is "ibus last", so dbus wins the first tie.
- **In GNT_x:**
  - `o_wb_*` is muxed combinationally from the granted master.
  - `o_wb_cyc = granted master's cyc`.
  - When the master is ibus: `o_wb_we=0`, `o_wb_sel=4'hF`, `o_wb_dat=0`.
- **Acknowledge routing:**
  - `o_ibus_ack = (state==GNT_I) & i_wb_ack`.
  - `o_dbus_ack` is formed the same way from GNT_D.
  - `i_wb_ack` in IDLE is ignored.
- **Read data:** `o_ibus_rdt` and `o_dbus_rdt` both carry `i_wb_rdt`, except during a timeout cycle (see below).
- **Leaving a grant state:**
  - On `i_wb_ack`, the FSM returns to IDLE and updates `last`.
  - If the granted master drops its cyc before ack, the transaction is aborted: the FSM returns to IDLE, `last` is left unchanged, and `o_wb_cyc` is already low that cycle.
- **Reset values:**
  - `o_wb_cyc=0`, `o_ibus_ack=0`, `o_dbus_ack=0`, `o_timeout=0`.
  - All address/data outputs are 0, because they are muxed from IDLE, which selects 0.

## Timing
- A request seen in IDLE at cycle N is granted at cycle N+1, where `o_wb_cyc` is high.
- With a combinational slave ack at N+1, the master ack is at N+1 and the FSM is back in IDLE at N+2. This gives a minimum of 2 cycles per transaction.
- Back-to-back requests: the next grant is at N+3.
- The ack-to-master path is combinational from `i_wb_ack`; no register stage is inserted.
- Simultaneous `i_wb_ack` and cyc drop in the same cycle counts as a completed transaction, and `last` is updated.
- Reset mid-transaction: the FSM goes to IDLE immediately (asynchronous), `o_wb_cyc` drops, and no ack is issued.

## Configuration
- **Macro `SERV_BUS_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on entry to GNT_x and increments each cycle in GNT_x without ack.
  - When the counter reaches `TIMEOUT_CYCLES`, the arbiter:
    - asserts the granted master's ack for one cycle;
    - drives that master's rdt to `ERR_RDATA`;
    - pulses `o_timeout`;
    - forces `o_wb_cyc` low the same cycle;
    - returns to IDLE and updates `last`.
  - A real `i_wb_ack` in the same cycle takes precedence: normal data is returned and there is no timeout pulse.
- **Macro not defined:**
  - There is no counter, and the arbiter waits indefinitely for ack.
  - `o_timeout` is tied to 0, and `ERR_RDATA` is unused.

## Structure
- Package `serv_bus_arb_pkg`: state enum (IDLE/GNT_I/GNT_D), the default `ERR_RDATA` constant, and the counter width localparam (16).
- Sub-module `serv_bus_arb_wdog` holds the timeout counter and compare, with inputs clr/en and output `fire`. It is instantiated only under `SERV_BUS_TIMEOUT_EN`.

## Test plan
- **Ibus read:** `i_ibus_cyc=1`, adr 0x100, slave acks 1 cycle after `o_wb_cyc` with rdt 0x00000013 → `o_wb_adr=0x100`, `o_wb_we=0`, `o_wb_sel=F`; `o_ibus_ack` for 1 cycle with `o_ibus_rdt=0x00000013`; `o_dbus_ack` stays 0.
- **Dbus write:** adr 0x8000_0004, dat 0xA5A5_0001, sel 4'b0011, we=1 → the same values appear on `o_wb_*`; a single `o_dbus_ack`.
- **Tie after reset:** both cyc high in IDLE → dbus granted first; after its ack, ibus is granted at +2 cycles.
- **Repeated ties:** 4 repeated ties → grants alternate D, I, D, I.
- **Abort:** dbus drops cyc 2 cycles into a grant with no ack → `o_wb_cyc` drops the same cycle, no master ack, and the next tie is still won by the same master as before the abort.
- **Timeout:** with `SERV_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, slave never acks → `o_ibus_ack`, `o_ibus_rdt=0xDEADBEEF` and `o_timeout` are asserted 8 cycles after the grant.
- **Timeout disabled:** without the macro, the arbiter is still granted after 1000 cycles and `o_timeout` stays 0.
- **Async reset:** assert `i_rst` asynchronously while in GNT_D → `o_wb_cyc` goes to 0 immediately, no ack is issued, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/serv_bus_arb_pkg.sv
// Shared types and constants for the SERV ibus/dbus arbiter.
// The optional watchdog is enabled by defining SERV_BUS_TIMEOUT_EN.
package serv_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
    localparam int          WDOG_W        = 16;

endpackage

// File: rtl/serv_bus_arbiter_if.sv
// Bundle of the ibus, dbus and shared Wishbone-style slave port around the arbiter.
// "slave" is the arbiter's own view; "master" is the view of whatever drives it.
interface serv_bus_arbiter_if;

    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;

    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;

    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;

    logic        o_timeout;

    modport slave (
        input  i_ibus_adr, i_ibus_cyc,
        input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        input  i_wb_rdt, i_wb_ack,
        output o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        output o_timeout
    );

    modport master (
        output i_ibus_adr, i_ibus_cyc,
        output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
        output i_wb_rdt, i_wb_ack,
        input  o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
        input  o_timeout
    );

endinterface

// File: rtl/serv_bus_arb_wdog.sv
// Grant watchdog: counts stalled grant cycles and flags when the count hits LIMIT.
// Only instantiated when SERV_BUS_TIMEOUT_EN is defined.
module serv_bus_arb_wdog
    import serv_bus_arb_pkg::*;
#(
    parameter logic [WDOG_W-1:0] LIMIT = 16'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic fire
);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fire = (cnt_q == LIMIT);

endmodule

// File: rtl/serv_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style slave port between SERV ibus and dbus.
// Define SERV_BUS_TIMEOUT_EN to terminate grants the slave never acknowledges.
module serv_bus_arbiter
    import serv_bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic               clk,
    input  logic               i_rst,
    serv_bus_arbiter_if.slave  bus
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;   // 1: dbus was the last master served
    logic       gnt_cyc;
    logic       wd_fire;
    logic       to_fire;
    logic       done;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("serv_bus_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    assign gnt_cyc = (state_q == GNT_I) ? bus.i_ibus_cyc :
                     (state_q == GNT_D) ? bus.i_dbus_cyc : 1'b0;

`ifdef SERV_BUS_TIMEOUT_EN
    serv_bus_arb_wdog #(
        .LIMIT (WDOG_W'(TIMEOUT_CYCLES))
    ) u_wdog (
        .clk  (clk),
        .rst  (i_rst),
        .clr  (state_q == IDLE),
        .en   (gnt_cyc & ~bus.i_wb_ack),
        .fire (wd_fire)
    );
`else
    assign wd_fire = 1'b0;
`endif

    // A real slave ack always wins over the watchdog in the same cycle.
    assign to_fire = (state_q != IDLE) & gnt_cyc & wd_fire & ~bus.i_wb_ack;
    assign done    = (state_q != IDLE) & (bus.i_wb_ack | to_fire);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.i_dbus_cyc && (!bus.i_ibus_cyc || !last_q)) begin
                    state_d = GNT_D;
                end else if (bus.i_ibus_cyc) begin
                    state_d = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                if (done) begin
                    state_d = IDLE;
                    last_d  = (state_q == GNT_D);
                end else if (!gnt_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_wb_adr   = '0;
        bus.o_wb_dat   = '0;
        bus.o_wb_sel   = '0;
        bus.o_wb_we    = 1'b0;
        bus.o_wb_cyc   = 1'b0;
        bus.o_ibus_ack = 1'b0;
        bus.o_dbus_ack = 1'b0;
        case (state_q)
            GNT_I: begin
                bus.o_wb_adr   = bus.i_ibus_adr;
                bus.o_wb_sel   = 4'hF;
                bus.o_wb_cyc   = bus.i_ibus_cyc & ~to_fire;
                bus.o_ibus_ack = bus.i_wb_ack | to_fire;
            end
            GNT_D: begin
                bus.o_wb_adr   = bus.i_dbus_adr;
                bus.o_wb_dat   = bus.i_dbus_dat;
                bus.o_wb_sel   = bus.i_dbus_sel;
                bus.o_wb_we    = bus.i_dbus_we;
                bus.o_wb_cyc   = bus.i_dbus_cyc & ~to_fire;
                bus.o_dbus_ack = bus.i_wb_ack | to_fire;
            end
            default: ;
        endcase
    end

    assign bus.o_ibus_rdt = (to_fire && (state_q == GNT_I)) ? ERR_RDATA : bus.i_wb_rdt;
    assign bus.o_dbus_rdt = (to_fire && (state_q == GNT_D)) ? ERR_RDATA : bus.i_wb_rdt;
    assign bus.o_timeout  = to_fire;

endmodule
